// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern, overlap control and a registered match pulse.
// Optional saturating match counter: define SEQ_DETECT_MATCH_CNT_EN; otherwise match_cnt is tied to zero.
module seq_detect_param #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             clr,
    output logic             match,
    output logic             primed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W) + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    // Two-bit encoding leaves spare codes so the recovery path is real logic.
    typedef enum logic [1:0] {
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               match_q, match_d;
    logic [PAT_W-1:0]   cand;
    logic               hit;

    assign cand = {hist_q, in};
    assign hit  = (state_q == ST_RUN) && (cand == pat_q);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        match_d = 1'b0;
        if (load || clr) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
            if (load) begin
                pat_d = pat_in;
            end
        end else if (in_valid) begin
            match_d = hit;
            case (state_q)
                ST_FILL: begin
                    hist_d = cand[PAT_W-2:0];
                    if (fill_q == FILL_LAST) begin
                        fill_d  = FILL_FULL;
                        state_d = ST_RUN;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    hist_d = cand[PAT_W-2:0];
                    // Non-overlapping: a match consumes the whole window.
                    if (hit && !overlap) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end
                end
                default: begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_RST;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            match_q <= match_d;
        end
    end

    assign match  = match_q;
    assign primed = (state_q == ST_RUN);

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven bench for seq_detect_param plus hand-written reset and counter-saturation sequences.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       load;
    logic [3:0] pat_in;
    logic       overlap;
    logic       clr;
    logic       match;
    logic       primed;
    logic [7:0] match_cnt;
    logic       sat_match;
    logic       sat_primed;
    logic [1:0] sat_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int sat_exp = 0;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .load(load),
        .pat_in(pat_in), .overlap(overlap), .clr(clr),
        .match(match), .primed(primed), .match_cnt(match_cnt)
    );

    seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .load(load),
        .pat_in(pat_in), .overlap(overlap), .clr(clr),
        .match(sat_match), .primed(sat_primed), .match_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       bit_in;
        logic       ld;
        logic       cl;
        logic       ov;
        logic [3:0] pat;
        logic       exp_match;
        logic       exp_primed;
        string      tag;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic b, input logic ld, input logic cl,
                                input logic ov, input logic [3:0] pat, input logic em,
                                input logic ep, input string tag);
        vec_t r;
        r.valid = v; r.bit_in = b; r.ld = ld; r.cl = cl; r.ov = ov; r.pat = pat;
        r.exp_match = em; r.exp_primed = ep; r.tag = tag;
        vq.push_back(r);
    endfunction

    task automatic drive(input logic v, input logic b, input logic ld, input logic cl,
                         input logic ov, input logic [3:0] pat);
        @(negedge clk);
        in_valid = v; in_bit = b; load = ld; clr = cl; overlap = ov; pat_in = pat;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t r);
        drive(r.valid, r.bit_in, r.ld, r.cl, r.ov, r.pat);
        if (r.cl) exp_cnt = 0;
        else if (r.exp_match && exp_cnt < 255) exp_cnt++;
        check({r.tag, "_match"}, int'(match), int'(r.exp_match));
        check({r.tag, "_primed"}, int'(primed), int'(r.exp_primed));
        check({r.tag, "_cnt"}, int'(match_cnt), CNT_ON ? exp_cnt : 0);
    endtask

    initial begin
        logic [3:0] gbits;
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; load = 1'b0;
        pat_in = 4'd0; overlap = 1'b1; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_match", int'(match), 0);
        check("reset_primed", int'(primed), 0);
        check("reset_cnt", int'(match_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // Overlapping: 1011011 -> matches after bits 4 and 7.
        add(1,1,0,0,1,0,0,0,"ov_b1"); add(1,0,0,0,1,0,0,0,"ov_b2");
        add(1,1,0,0,1,0,0,1,"ov_b3"); add(1,1,0,0,1,0,1,1,"ov_b4");
        add(1,0,0,0,1,0,0,1,"ov_b5"); add(1,1,0,0,1,0,0,1,"ov_b6");
        add(1,1,0,0,1,0,1,1,"ov_b7");
        add(0,0,0,1,1,0,0,0,"clr1");
        // Non-overlapping: same stream, one match, primed drops then returns.
        add(1,1,0,0,0,0,0,0,"no_b1"); add(1,0,0,0,0,0,0,0,"no_b2");
        add(1,1,0,0,0,0,0,1,"no_b3"); add(1,1,0,0,0,0,1,0,"no_b4");
        add(1,0,0,0,0,0,0,0,"no_b5"); add(1,1,0,0,0,0,0,0,"no_b6");
        add(1,1,0,0,0,0,0,1,"no_b7");
        add(0,0,0,1,1,0,0,0,"clr2");
        // Gaps: three idle cycles between valid bits, in toggling while idle.
        gbits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            add(1, gbits[3-i], 0,0,1,0, (i == 3), (i >= 2), "gap_bit");
            for (int g = 0; g < 3; g++) begin
                add(0, logic'(g % 2 == 0 ? ~gbits[3-i] : gbits[3-i]), 0,0,1,0, 0, (i >= 2), "gap_idle");
            end
        end
        add(0,0,0,1,1,0,0,0,"clr3");
        // Load mid-stream discards its bit and the history.
        add(1,1,0,0,1,0,0,0,"ld_b1"); add(1,0,0,0,1,0,0,0,"ld_b2");
        add(1,1,0,0,1,0,0,1,"ld_b3"); add(1,1,1,0,1,4'b0001,0,0,"ld_load");
        add(1,0,0,0,1,0,0,0,"ld_c1"); add(1,0,0,0,1,0,0,0,"ld_c2");
        add(1,0,0,0,1,0,0,1,"ld_c3"); add(1,1,0,0,1,0,1,1,"ld_c4");
        // Load and clr together, then 1011 matches the reloaded pattern.
        add(1,1,1,1,1,4'b1011,0,0,"ldclr");
        add(1,1,0,0,1,0,0,0,"lc_b1"); add(1,0,0,0,1,0,0,0,"lc_b2");
        add(1,1,0,0,1,0,0,1,"lc_b3"); add(1,1,0,0,1,0,1,1,"lc_b4");
        // Switching overlap off just before a completing bit ends in FILL.
        add(1,0,0,0,1,0,0,1,"sw_b5"); add(1,1,0,0,1,0,0,1,"sw_b6");
        add(1,1,0,0,0,0,1,0,"sw_b7"); add(1,1,0,0,1,0,0,0,"sw_b8");

        for (int k = 0; k < vq.size(); k++) apply(vq[k]);

        // Async reset right after a match pulse, pattern 0110 loaded beforehand.
        drive(0,0,1,1,1,4'b0110);
        exp_cnt = 0;
        drive(1,0,0,0,1,0); drive(1,1,0,0,1,0); drive(1,1,0,0,1,0); drive(1,0,0,0,1,0);
        check("pre_rst_match", int'(match), 1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_match", int'(match), 0);
        check("rst_primed", int'(primed), 0);
        check("rst_cnt", int'(match_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
        drive(1,1,0,0,1,0); drive(1,0,0,0,1,0); drive(1,1,0,0,1,0);
        check("post_rst_b3_match", int'(match), 0);
        drive(1,1,0,0,1,0);
        check("post_rst_b4_match", int'(match), 1);

        // Saturation on the CNT_W=2 instance: 8 ones against 1111 gives 5 matches.
        drive(0,0,1,1,1,4'b1111);
        sat_exp = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1,1,0,0,1,0);
            if (k >= 3 && sat_exp < 3) sat_exp++;
            check("sat_match", int'(sat_match), (k >= 3) ? 1 : 0);
            check("sat_cnt", int'(sat_cnt), CNT_ON ? sat_exp : 0);
        end
        drive(0,0,0,1,1,0);
        check("sat_clr_cnt", int'(sat_cnt), 0);
        check("sat_clr_primed", int'(sat_primed), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector; successor to the team's fixed 2-state "1 followed by 1" detector FSM.
- Compares a serial bit stream against a runtime-loadable PAT_W-bit pattern.
- Supports overlapping and non-overlapping match modes, an input qualifier, and a registered one-cycle match pulse.
- Sits between a serial front end and control logic that consumes match events.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..32
PAT_RST, 4'b1011 (width PAT_W), pattern register value after reset
CNT_W, 8, width of match counter (optional feature only)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  qualifies in; bit consumed only when high
in  input  1  serial data bit; first bit received aligns to pattern MSB
load  input  1  strobe: capture pat_in into pattern register
pat_in  input  PAT_W  new pattern value
overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
clr  input  1  synchronous clear of history, fill count and match counter
match  output  1  registered one-cycle pulse on pattern completion
primed  output  1  high when history holds PAT_W valid bits (state RUN)
match_cnt  output  CNT_W  saturating match count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): hist=0, fill=0, state=FILL, pat_reg=PAT_RST, match=0, primed=0, match_cnt=0.
- State register: two states.
  - FILL: fewer than PAT_W-1 valid bits held.
  - RUN: at least PAT_W-1 valid bits held, so the next valid bit can complete a match.
  - primed = (state==RUN).
- Fill counter: width clog2(PAT_W)+1; increments per consumed bit while in FILL.
  - FILL->RUN when a consumed bit brings fill to PAT_W-1.
  - Counter never exceeds PAT_W-1.
- Consumed bit (in_valid=1, load=0, clr=0):
  - hist <= {hist[PAT_W-2:0], in}.
  - cand = {hist[PAT_W-2:0], in}.
- Match: at the same edge a bit is consumed, match <= (state==RUN) && (cand==pat_reg); else match <= 0.
  - Latency: match is high for exactly the one cycle following the completing bit's edge.
- After a match:
  - overlap=1: stay in RUN; history retained.
  - overlap=0: hist<=0, fill<=0, state<=FILL; the next match needs PAT_W fresh bits.
- in_valid=0: hist, fill and state hold; match <= 0.
- load=1: pat_reg<=pat_in; hist, fill cleared; state<=FILL; match<=0; the in bit that cycle is discarded.
- clr=1: hist, fill, match_cnt cleared; state<=FILL; match<=0; in discarded; pattern retained.
- load and clr together: both actions apply.
- overlap sampled every cycle; a change takes effect from the next consumed bit.
- rst asserted mid-stream: all state returns immediately to reset values, including pat_reg.
- Unreachable state encoding: recover to FILL with fill=0.

Optional Feature:
Macro SEQ_DETECT_MATCH_CNT_EN.
- Defined: match_cnt increments by 1 on every cycle where match is set to 1.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared by clr or rst.
- Undefined: match_cnt port present but tied to 0; no counter flops.

Test Plan:
- Reset: rst=0 mid-stream, pattern previously loaded 4'b0110 -> match=0, primed=0, match_cnt=0; pat_reg=1011; the subsequent stream 1,0,1,1 produces match after the 4th bit.
- Overlap: PAT_W=4, pattern 1011, overlap=1, valid bits 1,0,1,1,0,1,1 -> match high after bit 4 and after bit 7; match_cnt=2.
- Non-overlap: same stream, overlap=0 -> match only after bit 4; primed drops after bit 4 and returns after bit 7; match_cnt=1.
- Gaps: pattern 1011 with in_valid=0 for 3 cycles between each bit, in toggling during gaps -> exactly one match, one cycle after the 4th valid bit; no match pulse during gaps.
- Load mid-stream: after bits 1,0,1, load pat_in=4'b0001 with in=1 -> no match; primed=0; then bits 0,0,0,1 -> match after 4th.
- Saturation (feature on, CNT_W=2): pattern 1111, overlap=1, 8 consecutive 1s -> 5 matches, match_cnt stops at 3; clr -> match_cnt=0, primed=0.
